// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the configurable UART blocks.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK,
    MAB
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: captures a clocks-per-bit value on load and strobes bit_end every D clocks.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 en,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] d_q;
  logic [DIV_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= DIV_WIDTH'(MIN_DIV);
      cnt_q <= '0;
    end else if (load) begin
      // Divisors below the minimum would make a bit shorter than two clocks.
      d_q   <= (div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div;
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  assign bit_end = en && (cnt_q == d_q - DIV_WIDTH'(1));

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with ready/valid input and runtime divisor.
// Optional line-break generation is enabled by defining UART_TX_CFG_BREAK_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 217
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_TX_Valid,
  output logic                 o_TX_Ready,
  input  logic [DATA_BITS-1:0] i_TX_Data,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  input  logic [DIV_WIDTH-1:0] i_Div,
  input  logic                 i_Div_Load,
  input  logic                 i_Break,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Active,
  output logic                 o_TX_Done
);

  localparam int unsigned CntW = 4;

  tx_state_e            state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] sreg_q, sreg_d;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 par_en_q, par_bit_q, two_stop_q;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;
  logic                 bit_end, timer_load, timer_en;
  logic                 brk, accept;

`ifdef UART_TX_CFG_BREAK_EN
  assign brk = i_Break;
`else
  logic unused_break;
  assign brk          = 1'b0;
  assign unused_break = i_Break;
`endif

  assign o_TX_Ready  = (state_q == IDLE) && !brk;
  assign accept      = i_TX_Valid && o_TX_Ready;
  assign o_TX_Active = (state_q == START) || (state_q == DATA) ||
                       (state_q == PARITY) || (state_q == STOP);
  assign o_TX_Serial = serial_q;
  assign o_TX_Done   = done_q;
  assign timer_en    = (state_q != IDLE) && (state_q != BREAK);

  uart_bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_timer (
    .clk    (i_Clock),
    .rst_n  (i_Reset_n),
    .load   (timer_load),
    .div    (div_q),
    .en     (timer_en),
    .bit_end(bit_end)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sreg_q     <= '0;
      div_q      <= DIV_WIDTH'(DEFAULT_DIV);
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      serial_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
      if (i_Div_Load) div_q <= i_Div;
      // Frame format is frozen at accept so mid-frame changes only hit the next word.
      if (accept) begin
        par_en_q   <= (i_Parity_Mode == PAR_EVEN) || (i_Parity_Mode == PAR_ODD);
        par_bit_q  <= (^i_TX_Data) ^ (i_Parity_Mode == PAR_ODD);
        two_stop_q <= i_Two_Stop;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sreg_d     = sreg_q;
    timer_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (brk) begin
          state_d = BREAK;
        end else if (accept) begin
          state_d    = START;
          sreg_d     = i_TX_Data;
          timer_load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sreg_d = sreg_q >> 1;
          if (bit_cnt_q == CntW'(DATA_BITS - 1)) begin
            state_d   = par_en_q ? PARITY : STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == {{(CntW-1){1'b0}}, two_stop_q}) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
`ifdef UART_TX_CFG_BREAK_EN
      BREAK: begin
        if (!brk) begin
          state_d    = MAB;
          timer_load = 1'b1;
        end
      end
      MAB: begin
        if (bit_end) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so the output stays registered.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      START, BREAK: serial_d = 1'b0;
      DATA:         serial_d = sreg_d[0];
      PARITY:       serial_d = par_bit_q;
      default:      serial_d = 1'b1;
    endcase
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (DATA_BITS=8).
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_TX_Valid;
  logic        o_TX_Ready;
  logic [7:0]  i_TX_Data;
  logic [1:0]  i_Parity_Mode;
  logic        i_Two_Stop;
  logic [15:0] i_Div;
  logic        i_Div_Load;
  logic        i_Break;
  logic        o_TX_Serial;
  logic        o_TX_Active;
  logic        o_TX_Done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .DATA_BITS  (8),
    .DIV_WIDTH  (16),
    .DEFAULT_DIV(217)
  ) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_TX_Valid   (i_TX_Valid),
    .o_TX_Ready   (o_TX_Ready),
    .i_TX_Data    (i_TX_Data),
    .i_Parity_Mode(i_Parity_Mode),
    .i_Two_Stop   (i_Two_Stop),
    .i_Div        (i_Div),
    .i_Div_Load   (i_Div_Load),
    .i_Break      (i_Break),
    .o_TX_Serial  (o_TX_Serial),
    .o_TX_Active  (o_TX_Active),
    .o_TX_Done    (o_TX_Done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_div(input logic [15:0] v);
    @(posedge clk); #1;
    i_Div      = v;
    i_Div_Load = 1'b1;
    @(posedge clk); #1;
    i_Div_Load = 1'b0;
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] data);
    @(posedge clk); #1;
    i_TX_Valid = 1'b1;
    i_TX_Data  = data;
    @(posedge clk); #1;
    i_TX_Valid = 1'b0;
  endtask

  // Called just after the accept edge; ends on the negedge of the Done cycle.
  task automatic check_frame(input logic [7:0] data, input int d, input logic [1:0] pm,
                             input logic ts);
    logic exp_bits [16];
    int   n;
    n = 0;
    exp_bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      exp_bits[n] = data[i]; n++;
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      exp_bits[n] = (^data) ^ (pm == 2'b10); n++;
    end
    exp_bits[n] = 1'b1; n++;
    if (ts) begin
      exp_bits[n] = 1'b1; n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < d; c++) begin
        @(negedge clk);
        check($sformatf("line_b%0d_c%0d", b, c), o_TX_Serial, exp_bits[b]);
        check("active_in_frame", o_TX_Active, 1);
        check("ready_in_frame", o_TX_Ready, 0);
        check("done_early", o_TX_Done, 0);
      end
    end
    @(negedge clk);
    check("done_pulse", o_TX_Done, 1);
    check("ready_at_done", o_TX_Ready, 1);
    check("active_at_done", o_TX_Active, 0);
    check("line_at_done", o_TX_Serial, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cnt;
    int guard;
    rst_n = 1'b0; i_TX_Valid = 1'b0; i_TX_Data = '0; i_Parity_Mode = 2'b00;
    i_Two_Stop = 1'b0; i_Div = '0; i_Div_Load = 1'b0; i_Break = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_serial", o_TX_Serial, 1);
    check("rst_ready", o_TX_Ready, 1);
    check("rst_active", o_TX_Active, 0);
    check("rst_done", o_TX_Done, 0);
    rst_n = 1'b1;

    // Default divisor 217: 0x01 keeps the line low for the start bit only
    send(8'h01);
    cnt = 0;
    @(negedge clk);
    while (o_TX_Serial === 1'b0 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("default_div_start_len", cnt, 217);
    guard = 0;
    while (o_TX_Done !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("default_done_seen", o_TX_Done, 1);
    check("default_frame_len", cnt + 1 + guard, 2171);

    // D=4, 8N1, 0xA5 -> 40 clocks
    load_div(16'd4);
    send(8'hA5);
    check_frame(8'hA5, 4, 2'b00, 1'b0);

    i_Parity_Mode = 2'b01;
    send(8'hA5);
    check_frame(8'hA5, 4, 2'b01, 1'b0);

    i_Parity_Mode = 2'b10;
    i_Two_Stop    = 1'b1;
    send(8'hA5);
    check_frame(8'hA5, 4, 2'b10, 1'b1);

    // Reserved parity mode behaves as none
    i_Parity_Mode = 2'b11;
    i_Two_Stop    = 1'b0;
    send(8'h5A);
    check_frame(8'h5A, 4, 2'b00, 1'b0);
    i_Parity_Mode = 2'b00;

    // Back-to-back with valid held high
    @(posedge clk); #1;
    i_TX_Valid = 1'b1;
    i_TX_Data  = 8'h3C;
    @(posedge clk); #1;
    i_TX_Data  = 8'hC3;
    check_frame(8'h3C, 4, 2'b00, 1'b0);
    @(posedge clk); #1;
    i_TX_Valid = 1'b0;
    check_frame(8'hC3, 4, 2'b00, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check("idle_after_b2b_line", o_TX_Serial, 1);
      check("idle_after_b2b_active", o_TX_Active, 0);
    end

    // Divisor 0 clamps to 2; mid-frame config changes apply to next frame only
    load_div(16'd0);
    send(8'h5A);
    fork
      check_frame(8'h5A, 2, 2'b00, 1'b0);
      begin
        repeat (3) @(posedge clk); #1;
        i_Div = 16'd8; i_Div_Load = 1'b1; i_Parity_Mode = 2'b10; i_Two_Stop = 1'b1;
        @(posedge clk); #1;
        i_Div_Load = 1'b0;
      end
    join
    send(8'h5A);
    check_frame(8'h5A, 8, 2'b10, 1'b1);
    i_Parity_Mode = 2'b00;
    i_Two_Stop    = 1'b0;

    // Asynchronous reset during data bit 3
    load_div(16'd4);
    send(8'hA5);
    repeat (18) @(negedge clk);
    check("pre_reset_bit3", o_TX_Serial, 0);
    check("pre_reset_active", o_TX_Active, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_serial", o_TX_Serial, 1);
    check("async_rst_active", o_TX_Active, 0);
    check("async_rst_ready", o_TX_Ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", o_TX_Ready, 1);
    check("post_rst_serial", o_TX_Serial, 1);
    load_div(16'd4);
    send(8'h3C);
    check_frame(8'h3C, 4, 2'b00, 1'b0);

`ifdef UART_TX_CFG_BREAK_EN
    // Break for 20 clocks with a competing valid, then one bit of mark
    @(posedge clk); #1;
    i_Break    = 1'b1;
    i_TX_Valid = 1'b1;
    i_TX_Data  = 8'hFF;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("break_line_%0d", i), o_TX_Serial, 0);
      check("break_ready", o_TX_Ready, 0);
      check("break_active", o_TX_Active, 0);
    end
    i_Break    = 1'b0;
    i_TX_Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mab_line_%0d", i), o_TX_Serial, 1);
      check("mab_ready", o_TX_Ready, 0);
      check("mab_active", o_TX_Active, 0);
    end
    @(negedge clk);
    check("after_mab_ready", o_TX_Ready, 1);
    check("after_mab_line", o_TX_Serial, 1);
    check("after_mab_active", o_TX_Active, 0);
`else
    // Break input has no effect in this build
    i_Break = 1'b1;
    send(8'h96);
    check_frame(8'h96, 4, 2'b00, 1'b0);
    i_Break = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter. It is the successor to the fixed N,8,1 transmitter. Adds configurable data width, parity, stop-bit count, runtime baud divisor and a ready/valid handshake that allows back-to-back frames. It sits between the host-side byte source (terminal/CPU FIFO) and the TX pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
DIV_WIDTH, 16, width of the runtime clocks-per-bit divisor
DEFAULT_DIV, 217, divisor used when i_Div_Load has never been pulsed since reset

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  asynchronous active-low reset
i_TX_Valid  in  1  data word offered
o_TX_Ready  out  1  block can accept a word this cycle
i_TX_Data  in  DATA_BITS  word to send, LSB first
i_Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none)
i_Two_Stop  in  1  0 = one stop bit, 1 = two stop bits
i_Div  in  DIV_WIDTH  clocks per bit
i_Div_Load  in  1  one-cycle strobe; captures i_Div into the divisor register
i_Break  in  1  break request (only used with the optional feature)
o_TX_Serial  out  1  serial line, idle high
o_TX_Active  out  1  high from the first start-bit clock to the last stop-bit clock
o_TX_Done  out  1  one-clock pulse at frame end

Behaviour:
- Reset (async assert, sync release): o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0, divisor=DEFAULT_DIV, state IDLE.
- Reset mid-frame aborts the frame immediately; the line returns high in the same instant, with no clock required.
- Divisor: effective value is max(divisor register, 2); a value of 0 or 1 is clamped to 2.
- Divisor, parity mode and stop count are latched at accept. Changes to i_Div_Load, i_Parity_Mode or i_Two_Stop mid-frame do not affect the frame in flight.
- Handshake: accept occurs when i_TX_Valid && o_TX_Ready. o_TX_Ready is high only in IDLE. i_TX_Data is latched on accept.
- States:
  - IDLE: accept -> START.
  - START -> DATA.
  - DATA: DATA_BITS bits, LSB first -> PARITY if enabled, else STOP.
  - PARITY -> STOP.
  - STOP: 1 or 2 bit-times -> IDLE.
- Every bit lasts exactly D clocks, where D is the effective divisor.
- o_TX_Serial is registered. The start bit is driven from the clock after accept.
- Parity:
  - Even: parity bit = XOR of the data bits.
  - Odd: parity bit = inverted XOR of the data bits.
- Frame end: on the last clock of the final stop bit, the state returns to IDLE. On the next clock, o_TX_Done=1 for one clock and o_TX_Ready=1.
- Back-to-back: a word accepted in the Done cycle starts its start bit on the following clock. The gap is zero idle bit-times.
- Frame length, accept to Done: (1 + DATA_BITS + P + S)·D clocks, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- Bit counter and clock counter wrap-free: each resets to 0 at every bit boundary.

Optional Feature:
- Macro: UART_TX_CFG_BREAK_EN
- Defined:
  - In IDLE with i_Break=1, the block drives o_TX_Serial=0 and holds o_TX_Ready=0 for as long as i_Break stays high.
  - On i_Break falling, the line is driven high for one full bit-time (mark-after-break) before o_TX_Ready returns to 1.
  - i_Break asserted mid-frame is ignored until the frame completes.
  - If i_Break and i_TX_Valid are both high in IDLE, break wins and the word is not accepted.
- Undefined: the i_Break port is still present but ignored, and no break state exists.

Decomposition:
- Package uart_pkg holds:
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the TX state encoding (IDLE, START, DATA, PARITY, STOP, BREAK, MAB);
  - MIN_DIV = 2.
- Sub-module uart_bit_timer: loads D, counts clocks, and emits a one-cycle bit_end strobe every D clocks while enabled. It will be reused by the future uart_rx_cfg.

Test Plan:
- DATA_BITS=8, D=4, no parity, 1 stop, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks. o_TX_Done pulses exactly 40 clocks after accept.
- Same word, even parity -> parity bit 0. Odd parity -> parity bit 1. With two stops the frame takes 48 clocks (11 bits + 1 extra stop = 12 bits).
- Two words offered with i_TX_Valid held high -> second start bit immediately follows the first stop bit. Ready is high exactly in the Done cycle.
- i_Div_Load with i_Div=0 -> every bit lasts 2 clocks. Loading i_Div=8 mid-frame changes only the next frame.
- Assert i_Reset_n=0 during data bit 3 -> o_TX_Serial=1 and o_TX_Active=0 without a clock edge. After release, o_TX_Ready=1 and the next frame is clean.
- With UART_TX_CFG_BREAK_EN, D=4: i_Break high for 20 clocks -> line low for 20 clocks, then high for 4 clocks with ready low, then ready=1. A concurrent i_TX_Valid is not accepted during break.
